// File: rtl/quad_enc_array.sv
// Multi-channel quadrature decoder: synchronise, glitch-filter and decode CHANNELS encoders,
// with sticky illegal-transition faults, per-channel clear and an atomic all-channel snapshot.
//
// state    | meaning
// ST_PRIME | post-reset settling; accepted/previous states track the synchronisers, no counting
// ST_RUN   | normal decode
module quad_enc_array #(
  parameter int CHANNELS    = 2,
  parameter int ENCBITS     = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          enc_a,
  input  logic [CHANNELS-1:0]          enc_b,
  input  logic [7:0]                   multiplier,
  input  logic [CHANNELS-1:0]          clear,
  input  logic                         snap_req,
  output logic [CHANNELS*ENCBITS-1:0]  count,
  output logic [CHANNELS*ENCBITS-1:0]  snapshot,
  output logic                         snap_valid,
  output logic [CHANNELS-1:0]          faultn
);

  localparam int LANES     = 2 * CHANNELS;
  localparam int PRIME_LEN = SYNC_STAGES + FILTER_LEN + 1;
  localparam int PW        = $clog2(PRIME_LEN + 1);
  localparam logic [PW-1:0] PRIME_LOAD = PW'(PRIME_LEN - 1);

  typedef enum logic {ST_PRIME = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                            state_q, state_d;
  logic [PW-1:0]                     prime_cnt_q, prime_cnt_d;
  logic                              prime;
  logic [LANES-1:0]                  sync_q [SYNC_STAGES];
  logic [LANES-1:0]                  sync_out;
  logic [LANES-1:0]                  acc;
  logic [LANES-1:0]                  prev_q, prev_d;
  logic [CHANNELS-1:0][ENCBITS-1:0]  count_q, count_d;
  logic [CHANNELS-1:0][ENCBITS-1:0]  snapshot_q, snapshot_d;
  logic                              snap_valid_q;
  logic [CHANNELS-1:0]               faultn_q, faultn_d;
  logic [ENCBITS-1:0]                mult_ext;
  logic [1:0]                        st_prev, st_cur;

  function automatic logic [1:0] fwd_next(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Prime timer: down-counter, leaves ST_PRIME on terminal count
  always_comb begin
    state_d     = state_q;
    prime_cnt_d = prime_cnt_q;
    if (state_q == ST_PRIME) begin
      if (prime_cnt_q == '0) state_d = ST_RUN;
      else                   prime_cnt_d = prime_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= ST_PRIME;
      prime_cnt_q <= PRIME_LOAD;
    end else begin
      state_q     <= state_d;
      prime_cnt_q <= prime_cnt_d;
    end
  end

  assign prime = (state_q == ST_PRIME);

  // Lanes [CHANNELS-1:0] carry A phases, upper lanes carry B phases
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= {enc_b, enc_a};
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  if (FILTER_LEN == 0) begin : g_nofilt
    assign acc = sync_out;
  end else begin : g_filt
    localparam int FW = (FILTER_LEN <= 2) ? 1 : $clog2(FILTER_LEN);
    localparam logic [FW-1:0] FILT_TC = FW'(FILTER_LEN - 1);

    logic [LANES-1:0] acc_q, acc_d;
    logic [FW-1:0]    fcnt_q [LANES];
    logic [FW-1:0]    fcnt_d [LANES];

    always_comb begin
      acc_d = acc_q;
      for (int l = 0; l < LANES; l++) begin
        fcnt_d[l] = '0;
        if (prime) begin
          acc_d[l] = sync_out[l];
        end else if (sync_out[l] != acc_q[l]) begin
          if (fcnt_q[l] == FILT_TC) acc_d[l] = sync_out[l];
          else                      fcnt_d[l] = fcnt_q[l] + 1'b1;
        end
      end
    end

    always_ff @(posedge CLK) begin
      if (reset) begin
        acc_q <= '0;
        for (int l = 0; l < LANES; l++) fcnt_q[l] <= '0;
      end else begin
        acc_q  <= acc_d;
        fcnt_q <= fcnt_d;
      end
    end

    assign acc = acc_q;
  end

  assign prev_d   = prime ? sync_out : acc;
  assign mult_ext = ENCBITS'(multiplier);

  // Clear wins over a coincident edge; prev_q still advances so the edge is consumed
  always_comb begin
    count_d  = count_q;
    faultn_d = faultn_q;
    st_prev  = '0;
    st_cur   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      st_prev = {prev_q[i], prev_q[CHANNELS+i]};
      st_cur  = {acc[i], acc[CHANNELS+i]};
      if (clear[i]) begin
        count_d[i]  = '0;
        faultn_d[i] = 1'b1;
      end else if (!prime) begin
        if (st_cur == fwd_next(st_prev))      count_d[i]  = count_q[i] + mult_ext;
        else if (st_prev == fwd_next(st_cur)) count_d[i]  = count_q[i] - mult_ext;
        else if (st_cur == ~st_prev)          faultn_d[i] = 1'b0;
      end
    end
  end

  assign snapshot_d = snap_req ? count_q : snapshot_q;

  always_ff @(posedge CLK) begin
    if (reset) begin
      prev_q       <= '0;
      count_q      <= '0;
      faultn_q     <= '1;
      snapshot_q   <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      count_q      <= count_d;
      faultn_q     <= faultn_d;
      snapshot_q   <= snapshot_d;
      snap_valid_q <= snap_req;
    end
  end

  assign count      = count_q;
  assign snapshot   = snapshot_q;
  assign snap_valid = snap_valid_q;
  assign faultn     = faultn_q;

endmodule
